// File: rtl/bi_2_line_pipe.sv
// -----------------------------------------------------------------------------
// bi_2_line_pipe
//
// Purpose:
//   Two-stage pipelined binary-to-one-hot decoder. It is the inverse of the
//   line-to-binary encoder. A binary bit index, such as a leading-one
//   position or a normalization shift count, is turned back into a one-hot
//   line vector for the mantissa datapath. Both sides use a valid/ready
//   handshake. The pipe buffers up to two items and streams one per cycle.
//
// Parameters:
//   IN_WIDTH   width of the binary index input
//   OUT_WIDTH  width of the one-hot output, OUT_WIDTH <= 2**IN_WIDTH
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   in_bin is valid this cycle
//   in_ready   block can accept in_bin this cycle
//   in_bin     binary index to decode
//   out_valid  out_line / out_err (/ out_mask) are valid
//   out_ready  downstream accepts the output this cycle
//   out_line   one-hot decode of the captured index
//   out_err    captured index was >= OUT_WIDTH; out_line is then all zeros
//   out_mask   (only with BI_2_LINE_THERMO_EN) thermometer mask, bits
//              [index:0] set; all ones for an out-of-range index
//
// Configuration macro:
//   BI_2_LINE_THERMO_EN  adds the registered out_mask output
// -----------------------------------------------------------------------------
module bi_2_line_pipe #(
    parameter int IN_WIDTH  = 5,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_bin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_line,
    output logic                 out_err
`ifdef BI_2_LINE_THERMO_EN
    ,
    output logic [OUT_WIDTH-1:0] out_mask
`endif
);

    if (OUT_WIDTH > (1 << IN_WIDTH)) begin : g_bad_width
        $error("bi_2_line_pipe: OUT_WIDTH must not exceed 2**IN_WIDTH");
    end

    // One extra bit so that OUT_WIDTH == 2**IN_WIDTH is still representable.
    localparam logic [IN_WIDTH:0] OUT_LIM = (IN_WIDTH + 1)'(OUT_WIDTH);

    logic                 s1_valid_q, s1_valid_d;
    logic [IN_WIDTH-1:0]  s1_bin_q,   s1_bin_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [OUT_WIDTH-1:0] line_q,     line_d;
    logic                 err_q,      err_d;
`ifdef BI_2_LINE_THERMO_EN
    logic [OUT_WIDTH-1:0] mask_q,     mask_d;
    logic [OUT_WIDTH-1:0] dec_mask;
`endif

    logic                 s2_adv;
    logic                 s1_adv;
    logic                 in_fire;
    logic                 in_range;
    logic [OUT_WIDTH-1:0] dec_line;

    // Handshake. in_ready depends on out_ready and state only, never on in_valid.
    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_adv;
    assign in_ready = !s1_valid_q || s2_adv;
    assign in_fire  = in_valid && in_ready;

    // Decode of the S1 index. An out-of-range index leaves every line bit
    // clear and every mask bit set without a separate branch, because the
    // index is then >= every bit position.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        dec_line = '0;
`ifdef BI_2_LINE_THERMO_EN
        dec_mask = '0;
`endif
        in_range = {1'b0, s1_bin_q} < OUT_LIM;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            dec_line[i] = (s1_bin_q == IN_WIDTH'(i));
`ifdef BI_2_LINE_THERMO_EN
            dec_mask[i] = ({1'b0, s1_bin_q} >= (IN_WIDTH + 1)'(i));
`endif
        end
    end

    // Next-state logic for both stages.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_bin_d   = s1_bin_q;
        s2_valid_d = s2_valid_q;
        line_d     = line_q;
        err_d      = err_q;
`ifdef BI_2_LINE_THERMO_EN
        mask_d     = mask_q;
`endif

        // A new input may replace an item leaving S1 in the same cycle.
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_bin_d   = in_bin;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        // The data fields only load on a real item and keep their last value
        // across bubbles.
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                line_d = dec_line;
                err_d  = !in_range;
`ifdef BI_2_LINE_THERMO_EN
                mask_d = dec_mask;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge value of its inputs.
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_bin_q   <= '0;
            s2_valid_q <= 1'b0;
            line_q     <= '0;
            err_q      <= 1'b0;
`ifdef BI_2_LINE_THERMO_EN
            mask_q     <= '0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_bin_q   <= s1_bin_d;
            s2_valid_q <= s2_valid_d;
            line_q     <= line_d;
            err_q      <= err_d;
`ifdef BI_2_LINE_THERMO_EN
            mask_q     <= mask_d;
`endif
        end
    end

    assign out_valid = s2_valid_q;
    assign out_line  = line_q;
    assign out_err   = err_q;
`ifdef BI_2_LINE_THERMO_EN
    assign out_mask  = mask_q;
`endif

endmodule

// File: tb/tb_bi_2_line_pipe.sv
// -----------------------------------------------------------------------------
// tb_bi_2_line_pipe
//
// Self-checking bench for bi_2_line_pipe. DUT "a" uses the default widths
// (5 -> 32) and runs against a reference model: a FIFO of accepted indices
// with a capacity of two. An item becomes visible one edge after the edge that
// accepted it, and its expected output is 1 << index. DUT "b" (5 -> 24)
// covers the out-of-range index. Set BI_2_LINE_THERMO_EN to cover out_mask.
// -----------------------------------------------------------------------------
module tb_bi_2_line_pipe;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, out_valid, out_ready, out_err;
    logic [4:0]  in_bin;
    logic [31:0] out_line;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
    logic [4:0]  b_in_bin;
    logic [23:0] b_out_line;

`ifdef BI_2_LINE_THERMO_EN
    logic [31:0] out_mask;
    logic [23:0] b_out_mask;
`endif

    bi_2_line_pipe #(.IN_WIDTH(5), .OUT_WIDTH(32)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_line  (out_line),
        .out_err   (out_err)
`ifdef BI_2_LINE_THERMO_EN
        ,
        .out_mask  (out_mask)
`endif
    );

    bi_2_line_pipe #(.IN_WIDTH(5), .OUT_WIDTH(24)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_bin    (b_in_bin),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_line  (b_out_line),
        .out_err   (b_out_err)
`ifdef BI_2_LINE_THERMO_EN
        ,
        .out_mask  (b_out_mask)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] bin;
        int         acc;
    } item_t;

    item_t q[$];
    int    cyc     = 0;
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle on DUT a: drive the inputs, compare against the model,
    // then advance the model across the rising edge.
    task automatic cycle(input logic v, input logic [4:0] b, input logic r);
        logic exp_rdy;
        logic exp_ov;
        @(negedge clk);
        in_valid  = v;
        in_bin    = b;
        out_ready = r;
        #1;
        exp_rdy = (q.size() < 2) || r;
        exp_ov  = (q.size() > 0) && ((cyc - q[0].acc) >= 1);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) begin
            check("out_line", out_line, 32'(1) << q[0].bin);
            check("out_err", 32'(out_err), 32'd0);
`ifdef BI_2_LINE_THERMO_EN
            check("out_mask", out_mask, 32'((64'd1 << (32'(q[0].bin) + 1)) - 64'd1));
`endif
        end
        @(posedge clk);
        cyc++;
        if (exp_ov && r) void'(q.pop_front());
        if (v && exp_rdy) q.push_back('{bin: b, acc: cyc});
    endtask

    // Reset with both DUTs offered an input while rst is high. The input
    // must be dropped.
    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        in_valid   = 1'b1;
        in_bin     = 5'd17;
        out_ready  = 1'b0;
        b_in_valid = 1'b1;
        b_in_bin   = 5'd3;
        @(posedge clk);
        q.delete();
        @(negedge clk);
        rst        = 1'b0;
        in_valid   = 1'b0;
        b_in_valid = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_line", out_line, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_bin      = '0;
        out_ready   = 1'b0;
        b_in_valid  = 1'b0;
        b_in_bin    = '0;
        b_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // Reset, then a single item: index 5 appears two cycles later for
        // one cycle only.
        cycle(1'b1, 5'd5, 1'b1);
        cycle(1'b0, 5'd0, 1'b1);
        #1;
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_line", out_line, 32'h0000_0020);
`ifdef BI_2_LINE_THERMO_EN
        check("single_mask", out_mask, 32'h0000_003F);
`endif
        repeat (2) cycle(1'b0, 5'd0, 1'b1);

        // Full streaming sweep 0..31 with both ends checked explicitly.
        for (int i = 0; i < 32; i++) begin
            cycle(1'b1, 5'(i), 1'b1);
            if (i == 1) begin
                #1;
                check("sweep_first", out_line, 32'h0000_0001);
            end
        end
        cycle(1'b0, 5'd0, 1'b1);
        #1;
        check("sweep_last", out_line, 32'h8000_0000);
        cycle(1'b0, 5'd0, 1'b1);

        // Backpressure: 3 and 7 fill the pipe and 9 is refused. The output
        // holds until out_ready returns.
        cycle(1'b1, 5'd3, 1'b0);
        cycle(1'b1, 5'd7, 1'b0);
        cycle(1'b1, 5'd9, 1'b0);
        #1;
        check("bp_hold_line", out_line, 32'h0000_0008);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        cycle(1'b1, 5'd9, 1'b1);
        #1;
        check("bp_second", out_line, 32'h0000_0080);
        cycle(1'b0, 5'd0, 1'b1);
        #1;
        check("bp_third", out_line, 32'h0000_0200);
        cycle(1'b0, 5'd0, 1'b1);
        cycle(1'b0, 5'd0, 1'b1);

        // Out-of-range index on the 24-line instance.
        @(negedge clk);
        b_in_valid  = 1'b1;
        b_in_bin    = 5'd24;
        b_out_ready = 1'b1;
        @(negedge clk);
        b_in_bin    = 5'd23;
        @(negedge clk);
        b_in_valid  = 1'b0;
        #1;
        check("oor_valid", 32'(b_out_valid), 32'd1);
        check("oor_line", 32'(b_out_line), 32'd0);
        check("oor_err", 32'(b_out_err), 32'd1);
`ifdef BI_2_LINE_THERMO_EN
        check("oor_mask", 32'(b_out_mask), 32'h00FF_FFFF);
`endif
        @(negedge clk);
        #1;
        check("b23_valid", 32'(b_out_valid), 32'd1);
        check("b23_line", 32'(b_out_line), 32'h0080_0000);
        check("b23_err", 32'(b_out_err), 32'd0);
        @(negedge clk);
        #1;
        check("b_drained", 32'(b_out_valid), 32'd0);

        // Reset mid-operation with two items held by backpressure. The model
        // is empty afterwards, so any stale output shows up as out_valid.
        cycle(1'b1, 5'd2, 1'b0);
        cycle(1'b1, 5'd4, 1'b0);
        do_reset();
        repeat (4) cycle(1'b0, 5'd0, 1'b1);

        // Random traffic against the model.
        for (int n = 0; n < 10000; n++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom), ($urandom_range(0, 3) != 0));
        end
        repeat (3) cycle(1'b0, 5'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
